neuron_backprop: RTL and testbench
==================================

# neuron_backprop

Sequential backward-pass unit for the N-input linear neuron (y = Σ x[i]·w[i] + b). Takes the upstream gradient dy for one sample plus the forward operands and produces the input gradients dx, weight gradients dw, and bias gradient db. It can optionally also produce SGD-updated weights and bias. One time-shared saturating Q8.8 multiplier serves all products. Sits between the loss/next-layer gradient source and the layer's weight store, with valid/ready handshakes on both sides.

## Interface
- N, 2, number of neuron inputs (≥1)
- B, 16, word width; signed two's-complement Q8.8 (8 fractional bits)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  unit can accept; reset 1
- x  in  [N-1:0][B-1:0]  forward inputs
- w  in  [N-1:0][B-1:0]  current weights
- b  in  B  current bias
- dy  in  B  upstream gradient
- lr  in  B  learning rate; Q8.8, used only in update mode
- out_valid  out  1  results valid; reset 0
- out_ready  in  1  downstream accepts results
- dx  out  [N-1:0][B-1:0]  dx[i] = dy·w[i]; reset 0
- dw  out  [N-1:0][B-1:0]  dw[i] = dy·x[i]; reset 0
- db  out  B  db = dy; reset 0
- w_new  out  [N-1:0][B-1:0]  updated weights; reset 0
- b_new  out  B  updated bias; reset 0

## Operation
- Accept: x, w, b, dy, and lr are captured into internal registers when in_valid && in_ready. Inputs are ignored at all other times.
- FSM states: IDLE → CALC → (UPDATE) → DONE → IDLE.
  - IDLE: in_ready=1. On accept, go to CALC and clear index k=0.
  - CALC: one product per cycle, 2N cycles total. Even step: dx[k] = dy·w[k]. Odd step: dw[k] = dy·x[k], then k++. db = dy is latched on accept.
  - UPDATE: present only with the macro; N+1 cycles. Step j<N: w_new[j] = w[j] − lr·dw[j]. Step N: b_new = b − lr·dy.
  - DONE: out_valid=1 and all outputs held stable. Go to IDLE on out_ready.
- in_ready is 1 only in IDLE. There is no overlap of samples.
- Multiply: full 2B-bit signed product, arithmetic right shift by 8 (truncation toward −∞), then saturate to [0x8000, 0x7FFF].
- Subtract: computed at B+1 bits, then saturated to B bits.
- rst in any state: next cycle is IDLE, in_ready=1, out_valid=0, and all outputs are 0. Any sample in flight is discarded.
- out_ready is ignored outside DONE.

## Timing
- Accept edge = cycle 0.
- Without macro: out_valid rises at cycle 2N+1 (5 for N=2).
- With macro: out_valid rises at cycle 3N+2 (8 for N=2).
- If out_ready is already high in DONE, out_valid lasts exactly 1 cycle. in_ready rises the cycle after the out handshake.
- Throughput: one sample per (latency + 1) cycles at minimum.
- Outputs are registered and change only while not in DONE.

## Configuration
- NEURON_BP_UPDATE_EN defined:
  - UPDATE state exists.
  - w_new and b_new are computed as above.
  - lr is captured.
- Not defined:
  - UPDATE state is removed.
  - w_new = captured w and b_new = captured b (pass-through).
  - lr is unused.
  - Latency is 2N+1.

## Structure
- Package neuron_pkg holds:
  - fxp_t typedef (logic signed [15:0])
  - FRAC_BITS=8, FXP_MAX=16'h7FFF, FXP_MIN=16'h8000
  - bp_state_t enum {IDLE, CALC, UPDATE, DONE}
- Sub-module fxp_mul_sat: combinational signed multiply, shift, and saturate. Instantiated once and muxed by FSM step.

## Test plan
- Basic gradient, N=2, no macro:
  - Stimulus: dy=0x0100, w={0x0200,0xFF00}, x={0x0080,0x0300}.
  - Response: dx={0x0200,0xFF00}, dw={0x0080,0x0300}, db=0x0100, out_valid at cycle 5.
- Update, with macro, same operands plus b=0x0100, lr=0x0080:
  - Response: w_new={0x01C0,0xFD80}, b_new=0x0080, out_valid at cycle 8.
- Saturation:
  - Stimulus: dy=0x7FFF, w={0x7FFF,0x8000}.
  - Response: dx={0x7FFF,0x8000}.
- Truncation:
  - Stimulus 1: dy=0x0001, w[0]=0x0001 → dx[0]=0x0000.
  - Stimulus 2: dy=0xFFFF, w[0]=0x0001 → dx[0]=0xFFFF.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles in DONE.
  - Response: outputs stable, in_ready=0, and an in_valid pulse is not accepted. After out_ready=1, out_valid drops the next cycle and in_ready=1.
- Mid-operation reset:
  - Stimulus: rst=1 at cycle 2 of CALC.
  - Response: next cycle out_valid=0, in_ready=1, all outputs 0. A new sample is then processed correctly.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared Q8.8 fixed-point type, saturation limits and backprop FSM states.
// Rev 1.0
`default_nettype none

package neuron_pkg;
   typedef logic signed [15:0] fxp_t;

   localparam int   FRAC_BITS = 8;
   localparam fxp_t FXP_MAX   = 16'h7FFF;
   localparam fxp_t FXP_MIN   = 16'h8000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } bp_state_t;
endpackage

`default_nettype wire

// File: rtl/fxp_mul_sat.sv
// fxp_mul_sat: combinational Q8.8 signed multiply, arithmetic shift (floor), saturate.
// Rev 1.0
`default_nettype none

module fxp_mul_sat
   import neuron_pkg::*;
(
   input  fxp_t i_a,
   input  fxp_t i_b,
   output fxp_t o_p
);
   localparam int FW = 2 * $bits(fxp_t);
   localparam int PW = FW - FRAC_BITS;

   logic signed [FW-1:0] w_full;
   logic signed [PW-1:0] w_shift;

   assign w_full  = i_a * i_b;
   assign w_shift = PW'(w_full >>> FRAC_BITS);

   always_comb begin
      o_p = w_shift[$bits(fxp_t)-1:0];
      if (w_shift > PW'(FXP_MAX))
         o_p = FXP_MAX;
      else if (w_shift < PW'(FXP_MIN))
         o_p = FXP_MIN;
   end
endmodule

`default_nettype wire

// File: rtl/neuron_backprop.sv
// neuron_backprop: time-shared backward pass (dx, dw, db) for an N-input linear neuron.
// Optional SGD weight/bias update enabled by NEURON_BP_UPDATE_EN. Rev 1.0
`default_nettype none

module neuron_backprop
   import neuron_pkg::*;
#(
   parameter int N = 2,
   parameter int B = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0][B-1:0] x,
   input  logic [N-1:0][B-1:0] w,
   input  logic [B-1:0]        b,
   input  logic [B-1:0]        dy,
   input  logic [B-1:0]        lr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N-1:0][B-1:0] dx,
   output logic [N-1:0][B-1:0] dw,
   output logic [B-1:0]        db,
   output logic [N-1:0][B-1:0] w_new,
   output logic [B-1:0]        b_new
);
   localparam int IW = $clog2(N + 1);

   bp_state_t r_state, w_next;

   logic [N-1:0][B-1:0] r_x, r_w, r_dx, r_dw, r_w_new;
   logic [B-1:0]        r_dy, r_db, r_b_new;
   logic [IW-1:0]       r_idx;
   logic                r_phase;
   logic [B-1:0]        w_sel_x, w_sel_w;
   fxp_t                w_mul_a, w_mul_b, w_prod;
   logic                w_calc_last;

`ifdef NEURON_BP_UPDATE_EN
   logic [B-1:0] r_b, r_lr, w_sel_dw, w_lhs;
   logic [B:0]   w_diff;
   fxp_t         w_sub;
`else
   logic w_unused_lr;
   assign w_unused_lr = ^lr;
`endif

   assign w_calc_last = r_phase && (r_idx == IW'(N - 1));

   always_comb begin
      w_sel_x = '0;
      w_sel_w = '0;
`ifdef NEURON_BP_UPDATE_EN
      w_sel_dw = '0;
`endif
      for (int i = 0; i < N; i++) begin
         if (r_idx == IW'(i)) begin
            w_sel_x = r_x[i];
            w_sel_w = r_w[i];
`ifdef NEURON_BP_UPDATE_EN
            w_sel_dw = r_dw[i];
`endif
         end
      end
      // Even CALC step forms dx (dy*w), odd step forms dw (dy*x).
      w_mul_a = r_dy;
      w_mul_b = r_phase ? w_sel_x : w_sel_w;
`ifdef NEURON_BP_UPDATE_EN
      if (r_state == UPDATE) begin
         w_mul_a = r_lr;
         w_mul_b = (r_idx == IW'(N)) ? r_dy : w_sel_dw;
      end
`endif
   end

   fxp_mul_sat u_mul (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_prod)
   );

`ifdef NEURON_BP_UPDATE_EN
   assign w_lhs  = (r_idx == IW'(N)) ? r_b : w_sel_w;
   assign w_diff = {w_lhs[B-1], w_lhs} - {w_prod[B-1], w_prod};
   assign w_sub  = (w_diff[B] != w_diff[B-1]) ? (w_diff[B] ? FXP_MIN : FXP_MAX)
                                              : w_diff[B-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = CALC;
         end
         CALC: begin
`ifdef NEURON_BP_UPDATE_EN
            if (w_calc_last) w_next = UPDATE;
`else
            if (w_calc_last) w_next = DONE;
`endif
         end
`ifdef NEURON_BP_UPDATE_EN
         UPDATE: begin
            if (r_idx == IW'(N)) w_next = DONE;
         end
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x     <= '0;
         r_w     <= '0;
         r_dy    <= '0;
         r_dx    <= '0;
         r_dw    <= '0;
         r_db    <= '0;
         r_w_new <= '0;
         r_b_new <= '0;
         r_idx   <= '0;
         r_phase <= 1'b0;
`ifdef NEURON_BP_UPDATE_EN
         r_b     <= '0;
         r_lr    <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_x     <= x;
                  r_w     <= w;
                  r_dy    <= dy;
                  r_db    <= dy;
                  r_idx   <= '0;
                  r_phase <= 1'b0;
`ifdef NEURON_BP_UPDATE_EN
                  r_b     <= b;
                  r_lr    <= lr;
`else
                  r_w_new <= w;
                  r_b_new <= b;
`endif
               end
            end
            CALC: begin
               for (int i = 0; i < N; i++) begin
                  if (r_idx == IW'(i)) begin
                     if (r_phase) r_dw[i] <= w_prod;
                     else         r_dx[i] <= w_prod;
                  end
               end
               r_phase <= ~r_phase;
               if (w_calc_last)  r_idx <= '0;
               else if (r_phase) r_idx <= r_idx + 1'b1;
            end
`ifdef NEURON_BP_UPDATE_EN
            UPDATE: begin
               for (int i = 0; i < N; i++) begin
                  if (r_idx == IW'(i)) r_w_new[i] <= w_sub;
               end
               if (r_idx == IW'(N)) r_b_new <= w_sub;
               r_idx <= r_idx + 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign dx    = r_dx;
   assign dw    = r_dw;
   assign db    = r_db;
   assign w_new = r_w_new;
   assign b_new = r_b_new;
endmodule

`default_nettype wire

// File: tb/tb_neuron_backprop.sv
// tb_neuron_backprop: directed vectors, scoreboard queue plus independent output monitor.
// Expectations follow NEURON_BP_UPDATE_EN when defined.
`default_nettype none

module tb_neuron_backprop;
   import neuron_pkg::*;

   localparam int N = 2;
   localparam int B = 16;
   // Edges from the accept edge to the edge entering DONE.
`ifdef NEURON_BP_UPDATE_EN
   localparam int LAT = 3 * N + 1;
`else
   localparam int LAT = 2 * N;
`endif

   typedef struct {
      logic [15:0] dx0, dx1, dw0, dw1, db, wn0, wn1, bn;
      int          acc;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid, in_ready, out_valid, out_ready;
   logic [N-1:0][B-1:0] x, w, dx, dw, w_new;
   logic [B-1:0]        b, dy, lr, db, b_new;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q[$];
   exp_t last_e;
   logic prev_ov = 1'b0;

   neuron_backprop #(.N(N), .B(B)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .w(w), .b(b), .dy(dy), .lr(lr),
      .out_valid(out_valid), .out_ready(out_ready),
      .dx(dx), .dw(dw), .db(db), .w_new(w_new), .b_new(b_new)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] dx0, dx1, dw0, dw1, dbv,
                               input logic [15:0] u0, u1, ub, p0, p1, pb);
      exp_t e;
      e.dx0 = dx0; e.dx1 = dx1; e.dw0 = dw0; e.dw1 = dw1; e.db = dbv;
`ifdef NEURON_BP_UPDATE_EN
      e.wn0 = u0; e.wn1 = u1; e.bn = ub;
`else
      e.wn0 = p0; e.wn1 = p1; e.bn = pb;
`endif
      e.acc = 0;
      return e;
   endfunction

   task automatic chk_outs(input string tag, input exp_t e);
      chk({tag, "_dx0"}, 32'(dx[0]), 32'(e.dx0));
      chk({tag, "_dx1"}, 32'(dx[1]), 32'(e.dx1));
      chk({tag, "_dw0"}, 32'(dw[0]), 32'(e.dw0));
      chk({tag, "_dw1"}, 32'(dw[1]), 32'(e.dw1));
      chk({tag, "_db"},  32'(db),    32'(e.db));
      chk({tag, "_wn0"}, 32'(w_new[0]), 32'(e.wn0));
      chk({tag, "_wn1"}, 32'(w_new[1]), 32'(e.wn1));
      chk({tag, "_bn"},  32'(b_new),    32'(e.bn));
   endtask

   // Monitor: every rising out_valid must match the oldest expected sample.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid && !prev_ov) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk_outs("mon", e);
               chk("latency", 32'(cyc - e.acc), 32'(LAT));
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic send(input logic [15:0] x0, x1, w0, w1, bb, ddy, llr, input exp_t e);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      x[0] = x0; x[1] = x1; w[0] = w0; w[1] = w1;
      b = bb; dy = ddy; lr = llr;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e.acc  = cyc;
      last_e = e;
      q.push_back(e);
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic run(input logic [15:0] x0, x1, w0, w1, bb, ddy, llr, input exp_t e);
      send(x0, x1, w0, w1, bb, ddy, llr, e);
      wait_out();
      @(negedge clk);
      chk("out_valid_one_cycle", 32'(out_valid), 32'd0);
      chk("in_ready_after_hs",   32'(in_ready),  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      x = '0; w = '0; b = '0; dy = '0; lr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk_outs("rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;

      // Basic gradient / update example
      run(16'h0080, 16'h0300, 16'h0200, 16'hFF00, 16'h0100, 16'h0100, 16'h0080,
          mk(16'h0200, 16'hFF00, 16'h0080, 16'h0300, 16'h0100,
             16'h01C0, 16'hFD80, 16'h0080, 16'h0200, 16'hFF00, 16'h0100));

      // Truncation: 1*1 ulp floors to 0
      run(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000,
          mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
             16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000));

      // Truncation toward -inf, negative dw, large lr
      run(16'hFF00, 16'h0200, 16'h0001, 16'h0100, 16'h0200, 16'hFFFF, 16'h7FFF,
          mk(16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 16'hFFFF,
             16'hFF82, 16'h0200, 16'h0280, 16'h0001, 16'h0100, 16'h0200));

      // Saturation both ways, under backpressure
      out_ready = 1'b0;
      send(16'h0100, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0100,
           mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'hFF80, 16'h7FFF,
              16'h0000, 16'h8080, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000));
      wait_out();
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk_outs("bp_hold", last_e);
         if (i == 3) begin
            x = '1; w = '1; dy = 16'h1234; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready",  32'(in_ready),  32'd1);
      repeat (3) @(negedge clk);
      chk("bp_no_ghost_accept", 32'(in_ready), 32'd1);

      // Reset while in CALC discards the sample
      send(16'h0080, 16'h0300, 16'h0200, 16'hFF00, 16'h0100, 16'h0100, 16'h0080,
           mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      void'(q.pop_back());
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      chk_outs("mid_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      run(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0200, 16'h0100,
          mk(16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200,
             16'hFF00, 16'hFF00, 16'hFE00, 16'h0100, 16'h0100, 16'h0000));

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
